// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bundle between the core's data-memory port and the
//   dmem_responder.
//
//   Request channel  : req_valid, req_ready, req_fcn (1=load, 0=store),
//                      req_typ (funct3), req_addr (byte address), req_wdata
//   Response channel : resp_valid, resp_ready, resp_rdata, resp_err
//   Status           : busy (responder holds a request)
//
//   modport slave  : responder side
//   modport master : core / requester side
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_fcn;
  logic [2:0]  req_typ;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_fcn, req_typ, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport master (
    output req_valid, req_fcn, req_typ, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the single-cycle RV32I datapath. Holds a
//   word-organised SRAM of 2**ADDR_W 32-bit words and answers each load or
//   store after a programmable LATENCY (1..15) so the core can be exercised
//   against a non-ideal memory. Byte/half/word accesses with RV32I load
//   extension; illegal funct3 values complete with resp_err=1 and no write.
//
//   Ports:
//     clk   : clock, all state updates on the rising edge
//     reset : asynchronous active-low reset (array contents are not reset)
//     bus   : dmem_responder_if.slave (request/response channels, busy)
//
//   Build option:
//     DMEM_MISALIGN_TRAP_EN defined   : misaligned half/word accesses complete
//                                       with resp_err=1, rdata=0, no write.
//     DMEM_MISALIGN_TRAP_EN undefined : misaligned addresses are force-aligned
//                                       (half clears addr[0], word addr[1:0]).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; captures it on req_valid
//   WAIT  | latency countdown; access performed at the edge that leaves WAIT
//   RESP  | response held stable until resp_ready
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        cnt_q;
  logic              fcn_q;
  logic [2:0]        typ_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic req_ready_c, resp_valid_c, busy_c;
  logic accept, access;

  // Upper address bits only alias onto the array, so they are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    busy_c       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_d = WAIT;
      end
      WAIT: begin
        busy_c = 1'b1;
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        busy_c       = 1'b1;
        resp_valid_c = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every request passes through WAIT for LATENCY edges (counter starts at
  // LATENCY-1 and the access happens on the edge that sees zero), so
  // resp_valid rises exactly LATENCY edges after acceptance, LATENCY=1 included.
  assign accept = (state_q == IDLE) && bus.req_valid;
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);

  // ---------------------------------------------------------------------
  // Access decode on the captured request
  // ---------------------------------------------------------------------
  logic [1:0]        lane_raw, lane;
  logic              is_half, is_word, illegal, acc_err;
  logic [ADDR_W-1:0] word_idx;

  assign lane_raw = addr_q[1:0];
  assign is_half  = (typ_q[1:0] == 2'b01);
  assign is_word  = (typ_q[1:0] == 2'b10);
  assign word_idx = addr_q[ADDR_W+1:2];

  // Loads accept funct3 0,1,2,4,5; stores accept 0,1,2.
  assign illegal = fcn_q ? ((typ_q[1:0] == 2'b11) || (typ_q[2] && typ_q[1:0] == 2'b10))
                         : (typ_q[2] || (typ_q[1:0] == 2'b11));

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (is_half && lane_raw[0]) || (is_word && (lane_raw != 2'b00));
  assign acc_err    = illegal || misaligned;
  assign lane       = lane_raw;
`else
  assign acc_err = illegal;
  assign lane    = is_word ? 2'b00 : (is_half ? {lane_raw[1], 1'b0} : lane_raw);
`endif

  // ---------------------------------------------------------------------
  // Array
  // ---------------------------------------------------------------------
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rd_word, shifted, load_data, store_data;
  logic [3:0]  byte_en;
  logic        mem_we;

  assign rd_word = mem[word_idx];
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = '0;
    case (typ_q)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'd0, shifted[7:0]};
      3'd5:    load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    byte_en    = 4'b0000;
    store_data = wdata_q;
    case (typ_q[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en    = 4'b1111;
        store_data = wdata_q;
      end
      default: begin
        byte_en    = 4'b0000;
        store_data = wdata_q;
      end
    endcase
  end

  // A reset while in WAIT forces IDLE, so access (and the write) never fires.
  assign mem_we = access && !fcn_q && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Capture, latency counter, response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      fcn_q   <= 1'b0;
      typ_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= 4'(LATENCY - 1);
        fcn_q   <= bus.req_fcn;
        typ_q   <= bus.req_typ;
        addr_q  <= bus.req_addr[ADDR_W+1:0];
        wdata_q <= bus.req_wdata;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (access) begin
        rdata_q <= (fcn_q && !acc_err) ? load_data : 32'd0;
        err_q   <= acc_err;
      end else if ((state_q == RESP) && bus.resp_ready) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int LAT   = 2;
  localparam int LAT4  = 4;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n, rst4_n, sel4;
  logic req_valid, req_fcn, resp_ready;
  logic [2:0]  req_typ;
  logic [31:0] req_addr, req_wdata;
  logic req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder_if bus();
  dmem_responder_if bus4();

  assign bus.req_valid  = req_valid & ~sel4;
  assign bus4.req_valid = req_valid & sel4;
  assign bus.req_fcn    = req_fcn;
  assign bus4.req_fcn   = req_fcn;
  assign bus.req_typ    = req_typ;
  assign bus4.req_typ   = req_typ;
  assign bus.req_addr   = req_addr;
  assign bus4.req_addr  = req_addr;
  assign bus.req_wdata  = req_wdata;
  assign bus4.req_wdata = req_wdata;
  assign bus.resp_ready  = resp_ready;
  assign bus4.resp_ready = resp_ready;

  assign req_ready  = sel4 ? bus4.req_ready  : bus.req_ready;
  assign resp_valid = sel4 ? bus4.resp_valid : bus.resp_valid;
  assign resp_rdata = sel4 ? bus4.resp_rdata : bus.resp_rdata;
  assign resp_err   = sel4 ? bus4.resp_err   : bus.resp_err;
  assign busy       = sel4 ? bus4.busy       : bus.busy;

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT4)) dut4 (
    .clk(clk), .reset(rst4_n), .bus(bus4)
  );

  // Reference model: memory as an array of words, access rules applied directly.
  function automatic void model_access(input logic f, input logic [2:0] t,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] rd, output logic er);
    int idx, lane, size;
    logic legal;
    logic [31:0] w, v;
    rd = 32'd0;
    er = 1'b0;
    idx  = int'((a >> 2) % DEPTH);
    lane = int'(a % 4);
    size = (t[1:0] == 2'd0) ? 1 : ((t[1:0] == 2'd1) ? 2 : 4);
    legal = f ? (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5) : (t <= 3'd2);
    if (!legal) begin
      er = 1'b1;
      return;
    end
    if (lane % size != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      er = 1'b1;
      return;
`else
      lane = lane - (lane % size);
`endif
    end
    w = model_mem[idx];
    if (f) begin
      v = w >> (8 * lane);
      case (t)
        3'd0:    rd = 32'($signed(v[7:0]));
        3'd1:    rd = 32'($signed(v[15:0]));
        3'd4:    rd = 32'(v[7:0]);
        3'd5:    rd = 32'(v[15:0]);
        default: rd = w;
      endcase
    end else begin
      for (int b = 0; b < size; b++) w[8*(lane+b) +: 8] = d[8*b +: 8];
      model_mem[idx] = w;
    end
  endfunction

  // Present one request; returns #1 after the acceptance edge with req_valid
  // dropped and the request lines scrambled.
  task automatic send(input logic f, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_fcn   = f;
    req_typ   = t;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_fcn   = 1'($urandom);
    req_typ   = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic run(input logic f, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                     input int hold, output int lat, output logic [31:0] rd, output logic er);
    resp_ready = (hold == 0);
    send(f, t, a, d);
    wait_resp(lat, rd, er);
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    vectors++;
    if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    vectors++;
    if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_word_round_trip();
    int lat; logic [31:0] rd, erd; logic er, eer;
    model_access(1'b0, 3'd2, 32'h10, 32'hDEADBEEF, erd, eer);
    run(1'b0, 3'd2, 32'h10, 32'hDEADBEEF, 0, lat, rd, er);
    if (lat !== LAT) begin miscompares++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT); end
    vectors++;
    if (er !== 1'b0) begin miscompares++; $display("FAIL sw_err: got %b want 0", er); end
    vectors++;
    model_access(1'b1, 3'd2, 32'h10, 32'd0, erd, eer);
    run(1'b1, 3'd2, 32'h10, 32'd0, 0, lat, rd, er);
    if (lat !== LAT) begin miscompares++; $display("FAIL lw_latency: got %0d want %0d", lat, LAT); end
    vectors++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      miscompares++; $display("FAIL lw_round_trip: got %h/%b want deadbeef/0", rd, er);
    end
    vectors++;
  endtask

  task automatic test_byte_ext();
    int lat; logic [31:0] rd, erd; logic er, eer;
    logic [31:0] want [4];
    logic [2:0]  typs [4];
    logic [31:0] addrs [4];
    model_access(1'b0, 3'd2, 32'h10, 32'h11223344, erd, eer);
    run(1'b0, 3'd2, 32'h10, 32'h11223344, 0, lat, rd, er);
    model_access(1'b0, 3'd0, 32'h13, 32'h00000080, erd, eer);
    run(1'b0, 3'd0, 32'h13, 32'h00000080, 0, lat, rd, er);
    want[0] = 32'h80223344; typs[0] = 3'd2; addrs[0] = 32'h10;
    want[1] = 32'hFFFFFF80; typs[1] = 3'd0; addrs[1] = 32'h13;
    want[2] = 32'h00000080; typs[2] = 3'd4; addrs[2] = 32'h13;
    want[3] = 32'hFFFF8022; typs[3] = 3'd1; addrs[3] = 32'h12;
    for (int i = 0; i < 4; i++) begin
      model_access(1'b1, typs[i], addrs[i], 32'd0, erd, eer);
      run(1'b1, typs[i], addrs[i], 32'd0, 0, lat, rd, er);
      if (rd !== want[i] || er !== 1'b0) begin
        miscompares++; $display("FAIL byte_ext[%0d]: got %h/%b want %h/0", i, rd, er, want[i]);
      end
      vectors++;
    end
  endtask

  task automatic test_backpressure();
    int lat, bad; logic [31:0] rd, erd; logic er, eer;
    model_access(1'b1, 3'd2, 32'h10, 32'd0, erd, eer);
    resp_ready = 1'b0;
    send(1'b1, 3'd2, 32'h10, 32'd0);
    wait_resp(lat, rd, er);
    if (lat !== LAT || rd !== erd) begin
      miscompares++; $display("FAIL bp_first: got lat %0d data %h want lat %0d data %h", lat, rd, LAT, erd);
    end
    vectors++;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_fcn = 1'b0; req_typ = 3'd2; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== erd || req_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    if (bad !== 0) begin miscompares++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    vectors++;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
      miscompares++; $display("FAIL bp_release: got ready %b valid %b data %h want 1 0 0", req_ready, resp_valid, resp_rdata);
    end
    vectors++;
    model_access(1'b1, 3'd2, 32'h10, 32'd0, erd, eer);
    run(1'b1, 3'd2, 32'h10, 32'd0, 0, lat, rd, er);
    if (rd !== erd) begin miscompares++; $display("FAIL bp_no_accept: got %h want %h", rd, erd); end
    vectors++;
  endtask

  task automatic test_wrap_illegal();
    int lat; logic [31:0] rd, erd; logic er, eer;
    model_access(1'b0, 3'd2, 32'h1010, 32'h5A5A5A5A, erd, eer);
    run(1'b0, 3'd2, 32'h1010, 32'h5A5A5A5A, 0, lat, rd, er);
    model_access(1'b1, 3'd2, 32'h0010, 32'd0, erd, eer);
    run(1'b1, 3'd2, 32'h0010, 32'd0, 0, lat, rd, er);
    if (rd !== 32'h5A5A5A5A || er !== 1'b0) begin
      miscompares++; $display("FAIL wrap: got %h/%b want 5a5a5a5a/0", rd, er);
    end
    vectors++;
    run(1'b1, 3'd3, 32'h0010, 32'd0, 0, lat, rd, er);
    if (rd !== 32'd0 || er !== 1'b1 || lat !== LAT) begin
      miscompares++; $display("FAIL illegal_load: got %h/%b lat %0d want 0/1 lat %0d", rd, er, lat, LAT);
    end
    vectors++;
    run(1'b0, 3'd5, 32'h0010, 32'h0, 0, lat, rd, er);
    if (er !== 1'b1) begin miscompares++; $display("FAIL illegal_store: got err %b want 1", er); end
    vectors++;
    run(1'b1, 3'd2, 32'h0010, 32'd0, 0, lat, rd, er);
    if (rd !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL illegal_store_nowrite: got %h want 5a5a5a5a", rd); end
    vectors++;
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd, erd, want_lw, want_mem; logic er, eer, want_err;
`ifdef DMEM_MISALIGN_TRAP_EN
    want_lw = 32'd0; want_err = 1'b1; want_mem = 32'h11223344;
`else
    want_lw = 32'h11223344; want_err = 1'b0; want_mem = 32'h1122BEEF;
`endif
    model_access(1'b0, 3'd2, 32'h10, 32'h11223344, erd, eer);
    run(1'b0, 3'd2, 32'h10, 32'h11223344, 0, lat, rd, er);
    model_access(1'b1, 3'd2, 32'h12, 32'd0, erd, eer);
    run(1'b1, 3'd2, 32'h12, 32'd0, 0, lat, rd, er);
    if (rd !== want_lw || er !== want_err) begin
      miscompares++; $display("FAIL misalign_lw: got %h/%b want %h/%b", rd, er, want_lw, want_err);
    end
    vectors++;
    model_access(1'b0, 3'd1, 32'h11, 32'h0000BEEF, erd, eer);
    run(1'b0, 3'd1, 32'h11, 32'h0000BEEF, 0, lat, rd, er);
    if (er !== want_err) begin miscompares++; $display("FAIL misalign_sh: got err %b want %b", er, want_err); end
    vectors++;
    model_access(1'b1, 3'd2, 32'h10, 32'd0, erd, eer);
    run(1'b1, 3'd2, 32'h10, 32'd0, 0, lat, rd, er);
    if (rd !== want_mem) begin miscompares++; $display("FAIL misalign_mem: got %h want %h", rd, want_mem); end
    vectors++;
  endtask

  task automatic test_random();
    int lat, hold; logic [31:0] rd, erd, a, d; logic er, eer, f; logic [2:0] t;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      a = 32'h100 + 32'(i * 4);
      model_access(1'b0, 3'd2, a, d, erd, eer);
      run(1'b0, 3'd2, a, d, 0, lat, rd, er);
    end
    for (int i = 0; i < 200; i++) begin
      f    = 1'($urandom_range(0, 1));
      t    = 3'($urandom_range(0, 7));
      a    = ($urandom & 32'hFFFFF000) | 32'h100 | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      d    = $urandom;
      hold = $urandom_range(0, 2);
      model_access(f, t, a, d, erd, eer);
      run(f, t, a, d, hold, lat, rd, er);
      if (rd !== erd) begin miscompares++; $display("FAIL rand_data[%0d]: got %h want %h", i, rd, erd); end
      vectors++;
      if (er !== eer) begin miscompares++; $display("FAIL rand_err[%0d]: got %b want %b", i, er, eer); end
      vectors++;
      if (lat !== LAT) begin miscompares++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, LAT); end
      vectors++;
    end
  endtask

  task automatic test_reset_midop();
    int lat, highs; logic [31:0] rd; logic er;
    sel4 = 1'b1;
    #1;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL l4_idle_ready: got %b want 1", req_ready); end
    vectors++;
    run(1'b0, 3'd2, 32'h20, 32'h12345678, 0, lat, rd, er);
    if (lat !== LAT4) begin miscompares++; $display("FAIL l4_latency: got %0d want %0d", lat, LAT4); end
    vectors++;
    send(1'b0, 3'd2, 32'h20, 32'hCAFEF00D);
    repeat (2) begin @(posedge clk); #1; end
    rst4_n = 1'b0;
    highs = 0;
    repeat (2) begin @(posedge clk); #1; if (resp_valid !== 1'b0) highs++; end
    rst4_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (resp_valid !== 1'b0) highs++; end
    if (highs !== 0) begin miscompares++; $display("FAIL midop_resp_valid: got %0d high cycles want 0", highs); end
    vectors++;
    run(1'b1, 3'd2, 32'h20, 32'd0, 0, lat, rd, er);
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      miscompares++; $display("FAIL midop_prior: got %h/%b want 12345678/0", rd, er);
    end
    vectors++;
    sel4 = 1'b0;
  endtask

  initial begin
    sel4 = 1'b0;
    rst_n = 1'b0; rst4_n = 1'b0;
    req_valid = 1'b0; req_fcn = 1'b0; req_typ = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; rst4_n = 1'b1;
    test_reset();
    test_word_round_trip();
    test_byte_ext();
    test_backpressure();
    test_wrap_illegal();
    test_misalign();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
